// File: rtl/period_to_freq.sv
// period_to_freq
//   Converts the period word from the edge-to-edge period counter into an
//   integer frequency in Hz: freq_out = floor(CLK_HZ / (period_in + 1)).
//   A sequential restoring divider produces one quotient bit per clock.
//   nosignal_in forces a 0 Hz reading and aborts any division in flight.
//
// Ports
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous, active-low reset
//   period_in    in   PERIOD_W  period count minus one
//   nosignal_in  in   1         high = no input edge seen
//   freq_out     out  OUT_W     last computed frequency in Hz, held
//   freq_valid   out  1         one-cycle pulse when freq_out is updated
//   busy         out  1         high while a division is in progress
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a new period value (or first value after nosignal)
// CALC  | restoring division, one quotient bit per clock, OUT_W clocks
// DONE  | publish quotient on freq_out, pulse freq_valid
module period_to_freq #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned PERIOD_W = 16,
   parameter int unsigned OUT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                nosignal_in,
   output logic [OUT_W-1:0]    freq_out,
   output logic                freq_valid,
   output logic                busy
);

   localparam int unsigned DIV_W  = PERIOD_W + 1;
   localparam int unsigned ITER_W = $clog2(OUT_W + 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(OUT_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [PERIOD_W-1:0] last_period;
   logic                have_last;
   logic [DIV_W-1:0]    divisor;
   logic [DIV_W-1:0]    remainder;
   logic [OUT_W-1:0]    quotient;
   logic [ITER_W-1:0]   iter;

   logic                period_changed;
   logic                last_iter;
   logic                load;
   logic                step;
   logic                publish;
   logic                clear_out;

   logic [DIV_W:0]      trial;
   logic                fits;
   logic [DIV_W-1:0]    remainder_nxt;

   // have_last=0 after reset or nosignal forces a fresh division even when
   // the period word itself has not moved.
   assign period_changed = !have_last || (period_in != last_period);
   assign last_iter      = (iter == ITER_LAST);

   // Restoring step: bring down the next dividend bit and subtract if it fits.
   // The remainder is always below the divisor, so trial < 2*divisor and the
   // difference always fits back into DIV_W bits.
   assign trial         = {remainder, quotient[OUT_W-1]};
   assign fits          = (trial >= {1'b0, divisor});
   assign remainder_nxt = fits ? DIV_W'(trial - {1'b0, divisor}) : trial[DIV_W-1:0];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; nosignal_in overrides every state.
   always_comb begin
      state_nxt = state;
      if (nosignal_in) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (period_changed) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output / control decode
   always_comb begin
      busy      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      publish   = 1'b0;
      case (state)
         IDLE: begin
            load = !nosignal_in && period_changed;
         end
         CALC: begin
            busy = 1'b1;
            step = !nosignal_in;
         end
         DONE: begin
            busy    = 1'b1;
            publish = !nosignal_in;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      // Report 0 Hz once: either a non-zero reading is being dropped or a
      // division is being thrown away. Held nosignal stays quiet.
      clear_out = nosignal_in && ((freq_out != '0) || (state != IDLE));
   end

   // Divider datapath and change tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_period <= '0;
         have_last   <= 1'b0;
         divisor     <= '0;
         remainder   <= '0;
         quotient    <= '0;
         iter        <= '0;
      end else if (nosignal_in) begin
         have_last <= 1'b0;
      end else if (load) begin
         last_period <= period_in;
         have_last   <= 1'b1;
         divisor     <= {1'b0, period_in} + DIV_W'(1);
         quotient    <= OUT_W'(CLK_HZ);
         remainder   <= '0;
         iter        <= '0;
      end else if (step) begin
         remainder <= remainder_nxt;
         quotient  <= {quotient[OUT_W-2:0], fits};
         iter      <= iter + ITER_W'(1);
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         freq_out   <= '0;
         freq_valid <= 1'b0;
      end else if (clear_out) begin
         freq_out   <= '0;
         freq_valid <= 1'b1;
      end else if (publish) begin
         freq_out   <= quotient;
         freq_valid <= 1'b1;
      end else begin
         freq_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_period_to_freq.sv
// Directed and randomized checks of period_to_freq against a plain
// arithmetic model freq = CLK_HZ / (period + 1).
module tb_period_to_freq;

   localparam int unsigned CLK_HZ   = 50_000_000;
   localparam int unsigned PERIOD_W = 16;
   localparam int unsigned OUT_W    = 32;
   localparam int          LAT      = OUT_W + 2;

   logic                clk;
   logic                rst;
   logic [PERIOD_W-1:0] period_in;
   logic                nosignal_in;
   logic [OUT_W-1:0]    freq_out;
   logic                freq_valid;
   logic                busy;

   int checks;
   int failures;
   int pulse_cnt;

   period_to_freq #(
      .CLK_HZ  (CLK_HZ),
      .PERIOD_W(PERIOD_W),
      .OUT_W   (OUT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .period_in  (period_in),
      .nosignal_in(nosignal_in),
      .freq_out   (freq_out),
      .freq_valid (freq_valid),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (freq_valid === 1'b1) pulse_cnt++;
   end

   function automatic logic [63:0] ref_freq(input int unsigned p);
      longint unsigned num;
      longint unsigned den;
      num = longint'(CLK_HZ);
      den = longint'(p) + 64'd1;
      return num / den;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max_ticks, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (freq_valid !== 1'b1 && n < max_ticks);
   endtask

   // exp_lat = 0 skips the latency comparison.
   task automatic expect_result(input string tag, input logic [63:0] exp_f, input int exp_lat);
      int n;
      wait_valid(200, n);
      check({tag, "_valid"}, {63'd0, freq_valid}, 64'd1);
      if (exp_lat > 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_freq"}, 64'(freq_out), exp_f);
   endtask

   int                  p0;
   int                  changes;
   logic [PERIOD_W-1:0] p;
   logic [PERIOD_W-1:0] prev;

   initial begin
      checks      = 0;
      failures    = 0;
      pulse_cnt   = 0;
      rst         = 1'b0;
      nosignal_in = 1'b0;
      period_in   = 16'd49999;

      // Reset state
      repeat (3) tick();
      check("rst_freq_out", 64'(freq_out), 64'd0);
      check("rst_valid", {63'd0, freq_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);

      // 1: release with 49999 held
      rst = 1'b1;
      expect_result("t1", 64'd1000, LAT);
      tick();
      check("t1_valid_drop", {63'd0, freq_valid}, 64'd0);
      check("t1_busy_after", {63'd0, busy}, 64'd0);
      p0 = pulse_cnt;
      repeat (50) tick();
      check("t1_no_repeat", 64'(pulse_cnt), 64'(p0));
      check("t1_hold", 64'(freq_out), 64'd1000);

      // 2: range corners
      p0 = pulse_cnt;
      period_in = 16'd0;
      expect_result("t2_p0", 64'd50000000, LAT);
      repeat (40) tick();
      check("t2_p0_pulses", 64'(pulse_cnt), 64'(p0 + 1));
      p0 = pulse_cnt;
      period_in = 16'd2;
      expect_result("t2_p2", 64'd16666666, LAT);
      repeat (40) tick();
      check("t2_p2_pulses", 64'(pulse_cnt), 64'(p0 + 1));
      p0 = pulse_cnt;
      period_in = 16'hFFFF;
      expect_result("t2_pmax", 64'd762, LAT);
      repeat (40) tick();
      check("t2_pmax_pulses", 64'(pulse_cnt), 64'(p0 + 1));

      // 3: change mid-division is deferred to the next IDLE cycle
      period_in = 16'd49999;
      repeat (11) tick();
      check("t3_busy_mid", {63'd0, busy}, 64'd1);
      period_in = 16'd24999;
      expect_result("t3_first", 64'd1000, 0);
      expect_result("t3_second", 64'd2000, LAT);

      // 4: nosignal aborts a division
      period_in = 16'd49999;
      repeat (6) tick();
      nosignal_in = 1'b1;
      p0 = pulse_cnt;
      tick();
      check("t4_busy", {63'd0, busy}, 64'd0);
      check("t4_valid", {63'd0, freq_valid}, 64'd1);
      check("t4_freq", 64'(freq_out), 64'd0);
      repeat (10) tick();
      check("t4_one_pulse", 64'(pulse_cnt), 64'(p0 + 1));
      check("t4_freq_held", 64'(freq_out), 64'd0);
      nosignal_in = 1'b0;
      expect_result("t4_recover", 64'd1000, LAT);

      // 5: async reset mid-division
      period_in = 16'd12345;
      repeat (10) tick();
      rst = 1'b0;
      #1;
      check("t5_rst_freq", 64'(freq_out), 64'd0);
      check("t5_rst_valid", {63'd0, freq_valid}, 64'd0);
      check("t5_rst_busy", {63'd0, busy}, 64'd0);
      period_in = 16'd999;
      repeat (2) tick();
      rst = 1'b1;
      expect_result("t5_after", 64'd50000, LAT);

      // 6: random sweep against the arithmetic model
      repeat (3) tick();
      prev    = 16'd999;
      changes = 0;
      p0      = pulse_cnt;
      for (int i = 0; i < 1000; i++) begin
         case (i)
            0:       p = 16'd0;
            1:       p = 16'hFFFF;
            2:       p = 16'd1;
            3:       p = 16'hFFFE;
            default: begin
               if ($urandom_range(0, 9) == 0) p = prev;
               else p = PERIOD_W'($urandom_range(0, 65535));
            end
         endcase
         period_in = p;
         if (p != prev) begin
            changes++;
            expect_result("sweep", ref_freq(int'(p)), LAT);
         end else begin
            repeat (OUT_W + 4) tick();
            check("sweep_hold", 64'(freq_out), ref_freq(int'(prev)));
         end
         prev = p;
      end
      repeat (3) tick();
      check("sweep_pulses", 64'(pulse_cnt - p0), 64'(changes));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
